// File: rtl/mem_responder.sv
// mem_responder: wait-state memory slave with MFC handshake for a MAR/MDR datapath
module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH = 512
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic        Write,
  input  logic [8:0]  Address,
  input  logic [31:0] DataIn,
  output logic [31:0] Mdatain,
  output logic        MFC,
  output logic        Busy,
  output logic        Err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic wr_q;
  logic [8:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] mem [DEPTH];
  logic start, bad, fire, in_range;
  logic [AW-1:0] idx;
  always_comb begin
    start = (state == IDLE) && (Read ^ Write);
    bad = (state == IDLE) && Read && Write;
    fire = (state == ACCESS) && (cnt == 4'd0);
    in_range = {23'd0, addr_q} < 32'(DEPTH);
    idx = AW'(addr_q);
    state_n = start ? ACCESS :
              fire ? DONE :
              (state == DONE && !Read && !Write) ? IDLE : state;
    MFC = (state == DONE);
    Busy = (state == ACCESS);
  end
  always_ff @(posedge Clock) begin
    if (clear) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge Clock) begin
    if (clear) begin
      cnt <= 4'd0;
      Mdatain <= 32'd0;
      Err <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= 9'd0;
      data_q <= 32'd0;
    end else begin
      Err <= bad;
      if (start) begin
        wr_q <= Write;
        addr_q <= Address;
        data_q <= DataIn;
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (fire && !wr_q) Mdatain <= in_range ? mem[idx] : 32'd0;
    end
  end
  // memory has no reset; clear only blocks a pending write
  always_ff @(posedge Clock) begin
    if (!clear && fire && wr_q && in_range) mem[idx] <= data_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven and directed checks of mem_responder
module tb_mem_responder;
  logic Clock, clear, Read, Write;
  logic [8:0] Address;
  logic [31:0] DataIn;
  logic [31:0] m0, m1, m2;
  logic mfc0, mfc1, mfc2, busy0, busy1, busy2, err0, err1, err2;
  int n_cmp = 0;
  int n_fail = 0;

  mem_responder #(.WAIT_CYCLES(2), .DEPTH(256)) dut0 (
    .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .Address(Address),
    .DataIn(DataIn), .Mdatain(m0), .MFC(mfc0), .Busy(busy0), .Err(err0));
  mem_responder #(.WAIT_CYCLES(0), .DEPTH(512)) dut1 (
    .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .Address(Address),
    .DataIn(DataIn), .Mdatain(m1), .MFC(mfc1), .Busy(busy1), .Err(err1));
  mem_responder #(.WAIT_CYCLES(5), .DEPTH(512)) dut2 (
    .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .Address(Address),
    .DataIn(DataIn), .Mdatain(m2), .MFC(mfc2), .Busy(busy2), .Err(err2));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic clr, rd, wr;
    logic [8:0] addr;
    logic [31:0] din, md;
    logic mfc, busy, err;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input logic c, r, w, input logic [8:0] a, input logic [31:0] d,
                     input logic [31:0] md, input logic f, b, e);
    vec_t v;
    v.clr = c; v.rd = r; v.wr = w; v.addr = a; v.din = d;
    v.md = md; v.mfc = f; v.busy = b; v.err = e;
    tbl.push_back(v);
  endtask

  // one complete access on dut0 (WAIT_CYCLES=2): three busy cycles, DONE, back to idle
  task automatic acc_rows(input logic r, w, input logic [8:0] a, input logic [31:0] d,
                          input logic [31:0] md_old, md_new);
    for (int i = 0; i < 3; i++) row(0, r, w, a, d, md_old, 0, 1, 0);
    row(0, r, w, a, d, md_new, 1, 0, 0);
    row(0, 0, 0, 9'd0, 32'd0, md_new, 0, 0, 0);
  endtask

  task automatic chk(input string n, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic c, r, w, input logic [8:0] a, input logic [31:0] d);
    clear = c; Read = r; Write = w; Address = a; DataIn = d;
  endtask

  task automatic do_acc(input logic r, w, input logic [8:0] a, input logic [31:0] d);
    int n;
    drive(0, r, w, a, d);
    n = 0;
    do begin
      step();
      n++;
    end while (!mfc0 && n < 20);
    chk("acc_done", 32'(mfc0), 32'd1);
    drive(0, 0, 0, 9'd0, 32'd0);
    step();
  endtask

  initial begin
    int first1, first2, b1, b2, n;
    drive(1, 0, 0, 9'd0, 32'd0);
    step();
    row(1, 0, 0, 9'd0, 32'd0, 32'd0, 0, 0, 0);
    acc_rows(0, 1, 9'h005, 32'hFFFFFFFB, 32'd0, 32'd0);
    acc_rows(1, 0, 9'h005, 32'd0, 32'd0, 32'hFFFFFFFB);
    row(0, 1, 1, 9'h005, 32'h0, 32'hFFFFFFFB, 0, 0, 1);
    row(0, 0, 0, 9'h000, 32'h0, 32'hFFFFFFFB, 0, 0, 0);
    acc_rows(0, 1, 9'h000, 32'h11111111, 32'hFFFFFFFB, 32'hFFFFFFFB);
    acc_rows(0, 1, 9'h100, 32'hDEADBEEF, 32'hFFFFFFFB, 32'hFFFFFFFB);
    acc_rows(1, 0, 9'h000, 32'd0, 32'hFFFFFFFB, 32'h11111111);
    acc_rows(1, 0, 9'h100, 32'd0, 32'h11111111, 32'h00000000);
    acc_rows(1, 0, 9'h005, 32'd0, 32'h00000000, 32'hFFFFFFFB);
    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
      step();
      chk($sformatf("row%0d mdata", i), m0, tbl[i].md);
      chk($sformatf("row%0d mfc", i), 32'(mfc0), 32'(tbl[i].mfc));
      chk($sformatf("row%0d busy", i), 32'(busy0), 32'(tbl[i].busy));
      chk($sformatf("row%0d err", i), 32'(err0), 32'(tbl[i].err));
    end

    // clear in the second ACCESS cycle aborts the write
    do_acc(0, 1, 9'h010, 32'h00000006);
    drive(0, 0, 1, 9'h010, 32'h12345678);
    step();
    drive(0, 0, 0, 9'h000, 32'h0);
    step();
    chk("abort_busy_before", 32'(busy0), 32'd1);
    drive(1, 0, 0, 9'h000, 32'h0);
    step();
    chk("abort_mdata", m0, 32'd0);
    chk("abort_mfc", 32'(mfc0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_err", 32'(err0), 32'd0);
    drive(0, 0, 0, 9'h000, 32'h0);
    step();
    chk("abort_idle_busy", 32'(busy0), 32'd0);
    do_acc(1, 0, 9'h010, 32'd0);
    chk("abort_readback", m0, 32'h00000006);

    // request held high after MFC must not restart
    drive(0, 1, 0, 9'h005, 32'd0);
    n = 0;
    do begin
      step();
      n++;
    end while (!mfc0 && n < 20);
    chk("held_mfc_rise", 32'(mfc0), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("held%0d mfc", i), 32'(mfc0), 32'd1);
      chk($sformatf("held%0d busy", i), 32'(busy0), 32'd0);
    end
    chk("held_mdata", m0, 32'hFFFFFFFB);
    drive(0, 0, 0, 9'h000, 32'd0);
    step();
    chk("held_release_mfc", 32'(mfc0), 32'd0);
    step();
    chk("held_release_busy", 32'(busy0), 32'd0);

    // inputs changing mid-access are ignored
    do_acc(0, 1, 9'h002, 32'hAAAA0002);
    do_acc(0, 1, 9'h003, 32'hBBBB0003);
    drive(0, 0, 1, 9'h002, 32'hCCCCCCCC);
    step();
    drive(0, 0, 1, 9'h003, 32'hDDDDDDDD);
    n = 0;
    do begin
      step();
      n++;
    end while (!mfc0 && n < 20);
    chk("chg_done", 32'(mfc0), 32'd1);
    drive(0, 0, 0, 9'h000, 32'd0);
    step();
    do_acc(1, 0, 9'h002, 32'd0);
    chk("chg_addr2", m0, 32'hCCCCCCCC);
    do_acc(1, 0, 9'h003, 32'd0);
    chk("chg_addr3", m0, 32'hBBBB0003);

    // latency sweep on WAIT_CYCLES=0 and 5
    drive(1, 0, 0, 9'h000, 32'd0);
    step();
    chk("sweep_reset_m2", m2, 32'd0);
    drive(0, 1, 0, 9'h000, 32'd0);
    first1 = 0; first2 = 0; b1 = 0; b2 = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (mfc1 && first1 == 0) first1 = i;
      if (mfc2 && first2 == 0) first2 = i;
      b1 += int'(busy1);
      b2 += int'(busy2);
    end
    chk("w0_mfc_step", 32'(first1), 32'd2);
    chk("w5_mfc_step", 32'(first2), 32'd7);
    chk("w0_busy_cycles", 32'(b1), 32'd1);
    chk("w5_busy_cycles", 32'(b2), 32'd6);
    drive(0, 0, 0, 9'h000, 32'd0);
    step();
    chk("w0_release", 32'(mfc1), 32'd0);
    chk("w5_release", 32'(mfc2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
